// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one memory port between fetch and load/store requesters,
//            favouring load/store but bounding fetch starvation.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int WORD_SIZE  = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 if_req,
    input  logic [WORD_SIZE-1:0] if_addr,
    output logic                 if_gnt,
    output logic                 if_rvalid,
    output logic [WORD_SIZE-1:0] if_rdata,
    input  logic                 ls_req,
    input  logic                 ls_we,
    input  logic [3:0]           ls_be,
    input  logic [WORD_SIZE-1:0] ls_addr,
    input  logic [WORD_SIZE-1:0] ls_wdata,
    output logic                 ls_gnt,
    output logic                 ls_rvalid,
    output logic [WORD_SIZE-1:0] ls_rdata,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [3:0]           mem_be,
    output logic [WORD_SIZE-1:0] mem_addr,
    output logic [WORD_SIZE-1:0] mem_wdata,
    input  logic                 mem_ack,
    input  logic [WORD_SIZE-1:0] mem_rdata
);

    localparam logic [3:0] C_STARVE_MAX = 4'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY_IF = 2'd1,
        ST_BUSY_LS = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [3:0]             r_starve;
    logic                   w_idle;
    logic                   w_if_win;
    logic                   w_if_gnt;
    logic                   w_ls_gnt;
    logic                   r_mem_req;
    logic                   r_mem_we;
    logic [3:0]             r_mem_be;
    logic [WORD_SIZE-1:0]   r_mem_addr;
    logic [WORD_SIZE-1:0]   r_mem_wdata;
    logic                   r_if_rvalid;
    logic                   r_ls_rvalid;
    logic [WORD_SIZE-1:0]   r_if_rdata;
    logic [WORD_SIZE-1:0]   r_ls_rdata;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_if_win = if_req && (!ls_req || (r_starve == C_STARVE_MAX));
    // Grants are combinational, so they are masked while reset is held.
    assign w_if_gnt = w_idle && !rst && w_if_win;
    assign w_ls_gnt = w_idle && !rst && ls_req && !w_if_win;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_if_gnt)      w_state_nxt = ST_BUSY_IF;
                else if (w_ls_gnt) w_state_nxt = ST_BUSY_LS;
            end
            ST_BUSY_IF, ST_BUSY_LS: begin
                if (mem_ack) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_starve <= 4'd0;
        end else if (w_if_gnt) begin
            r_starve <= 4'd0;
        end else if (w_ls_gnt && if_req && (r_starve != C_STARVE_MAX)) begin
            r_starve <= r_starve + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= 4'd0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            r_if_rdata  <= '0;
            r_ls_rdata  <= '0;
        end else begin
            r_if_rvalid <= 1'b0;
            r_ls_rvalid <= 1'b0;
            if (w_if_gnt) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= 1'b0;
                r_mem_be    <= 4'b1111;
                r_mem_addr  <= if_addr;
                r_mem_wdata <= '0;
            end else if (w_ls_gnt) begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= ls_we;
                r_mem_be    <= ls_be;
                r_mem_addr  <= ls_addr;
                r_mem_wdata <= ls_wdata;
            end else if (!w_idle && mem_ack) begin
                // Command fields keep their last value; only mem_req drops.
                r_mem_req <= 1'b0;
                if (r_state == ST_BUSY_IF) begin
                    r_if_rvalid <= 1'b1;
                    r_if_rdata  <= mem_rdata;
                end else begin
                    r_ls_rvalid <= 1'b1;
                    r_ls_rdata  <= mem_rdata;
                end
            end
        end
    end

    assign if_gnt    = w_if_gnt;
    assign ls_gnt    = w_ls_gnt;
    assign if_rvalid = r_if_rvalid;
    assign ls_rvalid = r_ls_rvalid;
    assign if_rdata  = r_if_rdata;
    assign ls_rdata  = r_ls_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

`default_nettype wire
